scu_stream_sched: RTL and testbench

- Round-robin scheduler that shares one stochastic in-stream divide/sqrt unit among N binary-domain requesters.
- Per job it arbitrates, clears the shared unit, and generates the requester's input bitstream from a binary operand with a bit-reversed-counter SNG.
- It then runs a warm-up window, counts ones of the unit's output over a 2^WIDTH-cycle window, and returns the binary count to the grantee.
- Sits between the binary register/bus side and the shared SC datapath.

---
 rtl/scu_stream_sched_if.sv | 24 ++
 rtl/scu_stream_sched.sv | 133 +++++++++++++
 tb/tb_scu_stream_sched.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scu_stream_sched_if.sv
// Requester-side bus of the stream scheduler: job requests, operands and
// unit selects in, one-hot grant, done pulse and the binary result out.
interface scu_stream_sched_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) ();
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] operand;
  logic [N-1:0]       mode;
  logic [N-1:0]       gnt;
  logic [N-1:0]       done;
  logic [WIDTH:0]     result;
  logic               busy;

  modport master (
    output req, operand, mode,
    input  gnt, done, result, busy
  );

  modport slave (
    input  req, operand, mode,
    output gnt, done, result, busy
  );
endinterface

// File: rtl/scu_stream_sched.sv
// Round-robin scheduler sharing one stochastic divide/sqrt unit among N
// binary requesters. Each job: arbitrate, clear the unit, feed it a
// bit-reversed-counter SNG stream of the latched operand, let it settle for
// WARM cycles, then count its output ones over 2^WIDTH cycles.
module scu_stream_sched #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int WARM  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  scu_stream_sched_if.slave    bus,
  output logic                 unit_clr,
  output logic                 unit_sel,
  output logic                 unit_in,
  input  logic                 unit_out
);

  localparam int          IW = (N > 1) ? $clog2(N) : 1;
  localparam int          WW = (WARM > 1) ? $clog2(WARM) : 1;
  localparam int unsigned NU = N;
  localparam int unsigned WU = WIDTH;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FLUSH = 3'd1;
  localparam logic [2:0] S_WARM  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    g_idx;
  logic [WIDTH-1:0] op_q;
  logic             mode_q;
  logic [WIDTH-1:0] phase;
  logic [WIDTH-1:0] phase_rev;
  logic [WW-1:0]    wcnt;
  logic [WIDTH-1:0] rcnt;
  logic [WIDTH:0]   ones;
  logic [WIDTH:0]   result_q;
  logic             pick_vld;
  logic [IW-1:0]    pick_idx;
  logic [N-1:0]     gnt_vec;

  // First requester at or after the RR pointer, wrapping mod N
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int unsigned k = 0; k < NU; k++) begin
      if (!pick_vld && bus.req[(32'(ptr) + k) % NU]) begin
        pick_vld = 1'b1;
        pick_idx = IW'((32'(ptr) + k) % NU);
      end
    end
  end

  // Bit-reversed phase so consecutive cycles spread ones evenly
  always_comb begin
    phase_rev = '0;
    for (int unsigned b = 0; b < WU; b++) begin
      phase_rev[b] = phase[WU-1-b];
    end
  end

  // One-hot decode of the current grantee
  always_comb begin
    gnt_vec        = '0;
    gnt_vec[g_idx] = 1'b1;
  end

  assign bus.gnt    = (state != S_IDLE) ? gnt_vec : '0;
  assign bus.done   = (state == S_DONE) ? gnt_vec : '0;
  assign bus.busy   = (state != S_IDLE);
  assign bus.result = result_q;
  assign unit_clr   = (state == S_FLUSH);
  assign unit_sel   = (state != S_IDLE) && mode_q;
  assign unit_in    = ((state == S_WARM) || (state == S_RUN)) && (phase_rev < op_q);

  // Job sequencing: grant, flush, warm-up, measurement window, completion
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      g_idx    <= '0;
      op_q     <= '0;
      mode_q   <= 1'b0;
      phase    <= '0;
      wcnt     <= '0;
      rcnt     <= '0;
      ones     <= '0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            g_idx  <= pick_idx;
            op_q   <= bus.operand[32'(pick_idx)*WIDTH +: WIDTH];
            mode_q <= bus.mode[pick_idx];
            state  <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          phase <= '0;
          wcnt  <= '0;
          rcnt  <= '0;
          ones  <= '0;
          state <= (WARM > 0) ? S_WARM : S_RUN;
        end
        S_WARM: begin
          phase <= phase + 1'b1;
          wcnt  <= wcnt + 1'b1;
          if (wcnt == WW'(WARM - 1)) state <= S_RUN;
        end
        S_RUN: begin
          phase <= phase + 1'b1;
          rcnt  <= rcnt + 1'b1;
          ones  <= ones + {{WIDTH{1'b0}}, unit_out};
          // result captures the final sample so it is already valid in DONE
          if (rcnt == '1) begin
            result_q <= ones + {{WIDTH{1'b0}}, unit_out};
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          ptr   <= (g_idx == IW'(N - 1)) ? '0 : g_idx + 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scu_stream_sched.sv
// Scoreboard bench for scu_stream_sched: one instance with WARM=16 and one
// with WARM=0, each with a selectable unit model (tie 0, tie 1, loopback).
`timescale 1ns/1ps
module tb_scu_stream_sched;

  localparam int N      = 4;
  localparam int W      = 8;
  localparam int WARM_A = 16;
  localparam int LAT_A  = WARM_A + 257;
  localparam int LAT_B  = 257;

  typedef struct {
    int unsigned idx;
    int unsigned op;
    logic        mode;
    int unsigned res;
  } job_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scu_stream_sched_if #(.N(N), .WIDTH(W)) ifa ();
  scu_stream_sched_if #(.N(N), .WIDTH(W)) ifb ();

  logic a_clr, a_sel, a_in, a_out;
  logic b_clr, b_sel, b_in, b_out;
  logic [1:0] uo_a, uo_b;   // 0: tie 0, 1: tie 1, 2: loop unit_in back

  assign a_out = (uo_a == 2'd2) ? a_in : uo_a[0];
  assign b_out = (uo_b == 2'd2) ? b_in : uo_b[0];

  scu_stream_sched #(.N(N), .WIDTH(W), .WARM(WARM_A)) u_dut_a (
    .clk(clk), .rst(rst), .bus(ifa),
    .unit_clr(a_clr), .unit_sel(a_sel), .unit_in(a_in), .unit_out(a_out)
  );

  scu_stream_sched #(.N(N), .WIDTH(W), .WARM(0)) u_dut_b (
    .clk(clk), .rst(rst), .bus(ifb),
    .unit_clr(b_clr), .unit_sel(b_sel), .unit_in(b_in), .unit_out(b_out)
  );

  int n_checks = 0;
  int n_err    = 0;
  job_t sb_a[$];
  job_t sb_b[$];
  int a_started = 0;
  int b_started = 0;

  logic [1:0]  tuo [4] = '{2'd1, 2'd0, 2'd2, 2'd2};
  int unsigned top [4] = '{32'h5A, 32'h9C, 32'h00, 32'hFF};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int unsigned exp_res(input logic [1:0] uo, input int unsigned op);
    case (uo)
      2'd2:    return op;
      2'd1:    return 32'd1 << W;
      default: return 32'd0;
    endcase
  endfunction

  task automatic push_a(input int unsigned idx, input int unsigned op, input logic m);
    job_t e;
    ifa.operand[idx*W +: W] = W'(op);
    ifa.mode[idx]           = m;
    e.idx = idx; e.op = op; e.mode = m; e.res = exp_res(uo_a, op);
    sb_a.push_back(e);
  endtask

  task automatic push_b(input int unsigned idx, input int unsigned op, input logic m);
    job_t e;
    ifb.operand[idx*W +: W] = W'(op);
    ifb.mode[idx]           = m;
    e.idx = idx; e.op = op; e.mode = m; e.res = exp_res(uo_b, op);
    sb_b.push_back(e);
  endtask

  task automatic wait_started_a(input int target, input int budget);
    int k = 0;
    while (a_started < target && k < budget) begin @(negedge clk); k++; end
    if (a_started < target) check("a_start_timeout", a_started, target);
  endtask

  task automatic wait_empty_a(input int budget);
    int k = 0;
    while ((sb_a.size() != 0 || ifa.busy) && k < budget) begin @(negedge clk); k++; end
    check("a_drain", sb_a.size(), 0);
  endtask

  task automatic wait_empty_b(input int budget);
    int k = 0;
    while ((sb_b.size() != 0 || ifb.busy) && k < budget) begin @(negedge clk); k++; end
    check("b_drain", sb_b.size(), 0);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_gnt"},    ifa.gnt, 0);
    check({tag, "_done"},   ifa.done, 0);
    check({tag, "_busy"},   ifa.busy, 0);
    check({tag, "_result"}, ifa.result, 0);
    check({tag, "_clr"},    a_clr, 0);
    check({tag, "_in"},     a_in, 0);
    check({tag, "_sel"},    a_sel, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor for instance A: job start, per-cycle grant shape, completion
  initial begin
    int   cyc = 0;
    int   start_cyc = 0;
    bit   hist [512];
    logic prev_busy = 1'b0;
    int   ones;
    job_t e;
    forever begin
      @(negedge clk);
      cyc++;
      hist[9'(cyc)] = a_in;
      if (ifa.busy) check("a_gnt_onehot", $onehot(ifa.gnt), 1);
      if (a_clr) begin
        a_started++;
        start_cyc = cyc;
        check("a_clr_prev_idle", prev_busy, 0);
        check("a_clr_unit_in", a_in, 0);
        check("a_clr_sb_nonempty", sb_a.size() != 0, 1);
        if (sb_a.size() != 0) begin
          check("a_clr_gnt", ifa.gnt, 32'd1 << sb_a[0].idx);
          check("a_clr_sel", a_sel, sb_a[0].mode);
        end
      end
      if (ifa.done != '0) begin
        if (sb_a.size() == 0) begin
          check("a_done_spurious", ifa.done, 0);
        end else begin
          e = sb_a.pop_front();
          check("a_done_vec", ifa.done, 32'd1 << e.idx);
          check("a_gnt_at_done", ifa.gnt, 32'd1 << e.idx);
          check("a_result", ifa.result, e.res);
          check("a_latency", cyc - start_cyc, LAT_A);
          check("a_sel_at_done", a_sel, e.mode);
          ones = 0;
          for (int k = 1; k <= (1 << W); k++) ones += int'(hist[9'(cyc - k)]);
          check("a_run_in_ones", ones, e.op);
        end
      end
      prev_busy = ifa.busy;
    end
  end

  // Monitor for instance B (no warm-up)
  initial begin
    int   cyc = 0;
    int   start_cyc = 0;
    job_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (b_clr) begin
        b_started++;
        start_cyc = cyc;
        check("b_clr_sb_nonempty", sb_b.size() != 0, 1);
        if (sb_b.size() != 0) check("b_clr_gnt", ifb.gnt, 32'd1 << sb_b[0].idx);
      end
      if (ifb.done != '0) begin
        if (sb_b.size() == 0) begin
          check("b_done_spurious", ifb.done, 0);
        end else begin
          e = sb_b.pop_front();
          check("b_done_vec", ifb.done, 32'd1 << e.idx);
          check("b_result", ifb.result, e.res);
          check("b_latency", cyc - start_cyc, LAT_B);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    ifa.req = '0; ifa.operand = '0; ifa.mode = '0;
    ifb.req = '0; ifb.operand = '0; ifb.mode = '0;
    uo_a = 2'd2; uo_b = 2'd2;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_a("rst0");
    rst = 1'b0;

    // Reset mid-RUN drops the job, which then restarts from IDLE
    push_a(0, 32'h21, 1'b0);
    ifa.req = 4'b0001;
    repeat (100) @(negedge clk);
    check("t1_busy_mid", ifa.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_a("t1_rst");
    rst = 1'b0;
    @(negedge clk);
    check("t1_restart_clr", a_clr, 1);
    check("t1_restart_gnt", ifa.gnt, 4'b0001);
    ifa.req = '0;
    wait_empty_a(400);

    // Single requester, loopback unit
    uo_a = 2'd2;
    push_a(2, 32'h40, 1'b0);
    ifa.req = 4'b0100;
    s = a_started;
    wait_started_a(s + 1, 10);
    ifa.req = '0;
    wait_empty_a(400);

    // Tie-1, tie-0 and operand extremes
    for (int t = 0; t < 4; t++) begin
      uo_a = tuo[t];
      push_a(3, top[t], 1'b1);
      ifa.req = 4'b1000;
      s = a_started;
      wait_started_a(s + 1, 10);
      ifa.req = '0;
      wait_empty_a(400);
    end

    // All requesting: round-robin 0,1,2,3,0
    do_reset();
    uo_a = 2'd2;
    push_a(0, 32'h11, 1'b0);
    push_a(1, 32'h22, 1'b0);
    push_a(2, 32'h33, 1'b0);
    push_a(3, 32'h44, 1'b0);
    push_a(0, 32'h11, 1'b0);
    ifa.req = 4'b1111;
    s = a_started;
    wait_started_a(s + 5, 1500);
    ifa.req = '0;
    wait_empty_a(600);

    // Mode routing and operand latched at grant
    do_reset();
    push_a(0, 32'h50, 1'b0);
    push_a(1, 32'h3A, 1'b1);
    ifa.req = 4'b0011;
    s = a_started;
    wait_started_a(s + 2, 700);
    ifa.req = '0;
    repeat (20) @(negedge clk);
    ifa.operand[1*W +: W] = 8'hF0;
    wait_empty_a(400);

    // No warm-up; req dropped mid-RUN still completes
    push_b(1, 32'h33, 1'b0);
    ifb.req = 4'b0010;
    s = 0;
    while (b_started < 1 && s < 10) begin @(negedge clk); s++; end
    check("b_started", b_started, 1);
    repeat (100) @(negedge clk);
    check("b_busy_mid", ifb.busy, 1);
    ifb.req = '0;
    wait_empty_b(400);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
